rr_arbiter_4x16: RTL and testbench

Round-robin arbiter that shares one 16-way decoded resource among 16 requesters. It selects one active requester per grant window and registers the winner as a 4-bit index plus enable. It drives an internal `decoder_4x16` that produces the one-hot grant vector. It sits in front of any block that uses a decoder_4x16 select bus, such as a bank select, row enable or shared-bus select, and replaces a hard-wired index source.

---
 rtl/rr_arbiter_4x16.sv | 139 +++++++++++++
 tb/tb_rr_arbiter_4x16.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/rr_arbiter_4x16.sv
// Round-robin arbiter for 16 requesters with a bounded hold time, driving a
// 4-to-16 decoder that turns the registered winner index into a one-hot grant.

module decoder_4x16 (
   input  logic [3:0]  idx,
   input  logic        en,
   output logic [15:0] dec
);

   always_comb begin
      dec = 16'h0000;
      if (en) begin
         dec[idx] = 1'b1;
      end
   end

endmodule

module rr_arbiter_4x16 #(
   parameter int unsigned HOLD_MAX = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] req,
   output logic [3:0]  gnt_idx,
   output logic        gnt_en,
   output logic [15:0] gnt
);

   localparam int unsigned CntW = $clog2(HOLD_MAX + 1);
   localparam logic [CntW-1:0] HoldMax = CntW'(HOLD_MAX);
   localparam logic [CntW-1:0] HoldOne = CntW'(1);

   typedef enum logic {StIdle, StGrant} state_e;

   state_e          state_q, state_d;
   logic [3:0]      ptr_q, ptr_d;
   logic [CntW-1:0] hold_cnt_q, hold_cnt_d;
   logic [3:0]      gnt_idx_q, gnt_idx_d;
   logic            gnt_en_q, gnt_en_d;

   logic [15:0]     cur_oh;
   logic [15:0]     others;
   logic [3:0]      next_start;

   // First set bit of vec scanning start, start+1, ... with 4-bit wrap.
   function automatic logic [3:0] sel(input logic [3:0] start, input logic [15:0] vec);
      logic [3:0] res;
      logic [3:0] cand;
      logic       found;
      res   = start;
      found = 1'b0;
      for (int i = 0; i < 16; i++) begin
         cand = start + 4'(i);
         if (!found && vec[cand]) begin
            res   = cand;
            found = 1'b1;
         end
      end
      return res;
   endfunction

   always_comb begin
      cur_oh     = 16'h0001 << gnt_idx_q;
      others     = req & ~cur_oh;
      next_start = gnt_idx_q + 4'd1;
   end

   always_comb begin
      state_d    = state_q;
      ptr_d      = ptr_q;
      hold_cnt_d = hold_cnt_q;
      gnt_idx_d  = gnt_idx_q;
      gnt_en_d   = gnt_en_q;

      unique case (state_q)
         StIdle: begin
            gnt_en_d = 1'b0;
            if (|req) begin
               gnt_idx_d  = sel(ptr_q, req);
               gnt_en_d   = 1'b1;
               hold_cnt_d = HoldOne;
               state_d    = StGrant;
            end
         end

         StGrant: begin
            if (!req[gnt_idx_q]) begin
               ptr_d = next_start;
               if (|others) begin
                  // Hand off on the same edge so no idle cycle appears.
                  gnt_idx_d  = sel(next_start, others);
                  hold_cnt_d = HoldOne;
               end else begin
                  gnt_en_d   = 1'b0;
                  hold_cnt_d = '0;
                  state_d    = StIdle;
               end
            end else if ((hold_cnt_q == HoldMax) && (|others)) begin
               ptr_d      = next_start;
               gnt_idx_d  = sel(next_start, others);
               hold_cnt_d = HoldOne;
            end else if (hold_cnt_q != HoldMax) begin
               hold_cnt_d = hold_cnt_q + HoldOne;
            end
         end

         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= StIdle;
         ptr_q      <= 4'h0;
         hold_cnt_q <= '0;
         gnt_idx_q  <= 4'h0;
         gnt_en_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         ptr_q      <= ptr_d;
         hold_cnt_q <= hold_cnt_d;
         gnt_idx_q  <= gnt_idx_d;
         gnt_en_q   <= gnt_en_d;
      end
   end

   assign gnt_idx = gnt_idx_q;
   assign gnt_en  = gnt_en_q;

   decoder_4x16 u_dec (
      .idx (gnt_idx_q),
      .en  (gnt_en_q),
      .dec (gnt)
   );

endmodule

// File: tb/tb_rr_arbiter_4x16.sv
// Directed bench: a vector table on a HOLD_MAX=2 arbiter plus a hand-written
// rotation sequence on a HOLD_MAX=1 arbiter.

module tb_rr_arbiter_4x16;

   logic        clk;
   logic        rst, rst1;
   logic [15:0] req, req1;
   logic [3:0]  gnt_idx, gnt_idx1;
   logic        gnt_en, gnt_en1;
   logic [15:0] gnt, gnt1;

   int checks = 0;
   int errors = 0;

   rr_arbiter_4x16 #(.HOLD_MAX(2)) u_dut (
      .clk     (clk),
      .rst     (rst),
      .req     (req),
      .gnt_idx (gnt_idx),
      .gnt_en  (gnt_en),
      .gnt     (gnt)
   );

   rr_arbiter_4x16 #(.HOLD_MAX(1)) u_dut1 (
      .clk     (clk),
      .rst     (rst1),
      .req     (req1),
      .gnt_idx (gnt_idx1),
      .gnt_en  (gnt_en1),
      .gnt     (gnt1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        rst;
      logic [15:0] req;
      logic        en;
      logic [3:0]  idx;
      logic [15:0] gnt;
   } vec_t;

   localparam int NumVec = 32;
   vec_t vecs[NumVec];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   initial begin
      rst  = 1'b1;
      req  = 16'hFFFF;
      rst1 = 1'b1;
      req1 = 16'h0007;

      // reset held two cycles, then first grant to index 0
      vecs[0]  = '{1'b1, 16'hFFFF, 1'b0, 4'd0,  16'h0000};
      vecs[1]  = '{1'b1, 16'hFFFF, 1'b0, 4'd0,  16'h0000};
      vecs[2]  = '{1'b0, 16'hFFFF, 1'b1, 4'd0,  16'h0001};
      vecs[3]  = '{1'b0, 16'h0000, 1'b0, 4'd0,  16'h0000};
      // single request, then drop: index is retained
      vecs[4]  = '{1'b0, 16'h0020, 1'b1, 4'd5,  16'h0020};
      vecs[5]  = '{1'b0, 16'h0000, 1'b0, 4'd5,  16'h0000};
      vecs[6]  = '{1'b0, 16'h0000, 1'b0, 4'd5,  16'h0000};
      // fairness with HOLD_MAX=2 from a fresh pointer
      vecs[7]  = '{1'b1, 16'h8001, 1'b0, 4'd0,  16'h0000};
      vecs[8]  = '{1'b0, 16'h8001, 1'b1, 4'd0,  16'h0001};
      vecs[9]  = '{1'b0, 16'h8001, 1'b1, 4'd0,  16'h0001};
      vecs[10] = '{1'b0, 16'h8001, 1'b1, 4'd15, 16'h8000};
      vecs[11] = '{1'b0, 16'h8001, 1'b1, 4'd15, 16'h8000};
      vecs[12] = '{1'b0, 16'h8001, 1'b1, 4'd0,  16'h0001};
      vecs[13] = '{1'b0, 16'h8001, 1'b1, 4'd0,  16'h0001};
      vecs[14] = '{1'b0, 16'h8001, 1'b1, 4'd15, 16'h8000};
      vecs[15] = '{1'b0, 16'h8001, 1'b1, 4'd15, 16'h8000};
      // back-to-back handoff 3 -> 9, then release to idle
      vecs[16] = '{1'b0, 16'h0208, 1'b1, 4'd3,  16'h0008};
      vecs[17] = '{1'b0, 16'h0208, 1'b1, 4'd3,  16'h0008};
      vecs[18] = '{1'b0, 16'h0200, 1'b1, 4'd9,  16'h0200};
      vecs[19] = '{1'b0, 16'h0000, 1'b0, 4'd9,  16'h0000};
      // wrap-around: pointer left at 15
      vecs[20] = '{1'b0, 16'h4000, 1'b1, 4'd14, 16'h4000};
      vecs[21] = '{1'b0, 16'h0000, 1'b0, 4'd14, 16'h0000};
      vecs[22] = '{1'b0, 16'h0003, 1'b1, 4'd0,  16'h0001};
      vecs[23] = '{1'b0, 16'h0002, 1'b1, 4'd1,  16'h0002};
      vecs[24] = '{1'b0, 16'h0000, 1'b0, 4'd1,  16'h0000};
      // reset mid-grant, then hold counter restarts from 1
      vecs[25] = '{1'b0, 16'h0010, 1'b1, 4'd4,  16'h0010};
      vecs[26] = '{1'b0, 16'h0010, 1'b1, 4'd4,  16'h0010};
      vecs[27] = '{1'b0, 16'h0010, 1'b1, 4'd4,  16'h0010};
      vecs[28] = '{1'b1, 16'h0010, 1'b0, 4'd0,  16'h0000};
      vecs[29] = '{1'b0, 16'h0010, 1'b1, 4'd4,  16'h0010};
      vecs[30] = '{1'b0, 16'h0011, 1'b1, 4'd4,  16'h0010};
      vecs[31] = '{1'b0, 16'h0011, 1'b1, 4'd0,  16'h0001};

      for (int i = 0; i < NumVec; i++) begin
         @(negedge clk);
         rst = vecs[i].rst;
         req = vecs[i].req;
         @(posedge clk);
         #1;
         chk($sformatf("v%0d gnt_en", i), 32'(gnt_en), 32'(vecs[i].en));
         chk($sformatf("v%0d gnt_idx", i), 32'(gnt_idx), 32'(vecs[i].idx));
         chk($sformatf("v%0d gnt", i), 32'(gnt), 32'(vecs[i].gnt));
      end

      // HOLD_MAX=1 with three requesters rotates every cycle
      begin
         logic [3:0] rot_exp[6];
         rot_exp[0] = 4'd0;
         rot_exp[1] = 4'd1;
         rot_exp[2] = 4'd2;
         rot_exp[3] = 4'd0;
         rot_exp[4] = 4'd1;
         rot_exp[5] = 4'd2;
         @(negedge clk);
         rst1 = 1'b0;
         for (int k = 0; k < 6; k++) begin
            @(posedge clk);
            #1;
            chk($sformatf("rot%0d gnt_en", k), 32'(gnt_en1), 32'd1);
            chk($sformatf("rot%0d gnt_idx", k), 32'(gnt_idx1), 32'(rot_exp[k]));
            chk($sformatf("rot%0d gnt", k), 32'(gnt1), 32'(16'h0001 << rot_exp[k]));
         end
         @(negedge clk);
         req1 = 16'h0000;
         @(posedge clk);
         #1;
         chk("rot release gnt_en", 32'(gnt_en1), 32'd0);
         chk("rot release gnt", 32'(gnt1), 32'd0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
